snes_pad_responder: RTL and testbench
=====================================

Name: snes_pad_responder

Overview:
- Device side of the SNES controller serial protocol; the pad end of the link that `wtm_snesJoysticks` drives as host.
- Samples the host's `snes_latch` and `snes_clock` and shifts a 16-bit button word out on `snes_data`.
- Used in two places:
  - As a bench model for the joystick reader.
  - As an FPGA-side pad emulator, so a CPU-written button word appears to a host as a real controller.

Parameters:
- CLOCK_FREQ_HZ, 18181818: frequency of `clock`; used only to size the timeout counter.
- TIMEOUT_US, 50000: `host_active` drops if no latch is seen for this many microseconds.
- FILTER_CYCLES, 2: number of consecutive synchronized samples required to accept a level change on latch or clock (range 1..7).

Ports:
- clock, in, 1: system clock; all logic is on its rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- buttons, in, 16: button word, active-high (1 = pressed). Bit 0 = B, sent first; order is B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then ID bits 12..15 last.
- snes_latch, in, 1: host latch; asynchronous to `clock`.
- snes_clock, in, 1: host shift clock; idles high; asynchronous to `clock`.
- snes_data, out, 1: serial data; active-low on the wire.
- frame_done, out, 1: one-cycle pulse when the 16th bit has been shifted past.
- frame_count, out, 8: number of completed frames; wraps.
- host_active, out, 1: 1 while latches arrive within the timeout.

Behaviour:

Input conditioning
- Both `snes_latch` and `snes_clock` pass through a 2-FF synchronizer, then the FILTER_CYCLES glitch filter.
- A filtered level updates only after FILTER_CYCLES identical consecutive samples.
- Edge pulses (`latch_rise`, `latch_fall`, `clk_rise`) are derived from the filtered levels.
- Pin-to-`snes_data` latency is 2 + FILTER_CYCLES + 1 clocks (5 at default); this is a fixed requirement.

Reset values
- `snes_data` = 1; `frame_done` = 0; `frame_count` = 0; `host_active` = 0.
- Shift register = 16'hFFFF; bit index = 0; state = IDLE.
- Filtered latch = 0; filtered clock = 1.

State machine
- IDLE: `snes_data` = 1. `latch_rise` → LOAD.
- LOAD (filtered latch high):
  - Every cycle, shift register ← ~buttons (parallel load; the pad is transparent while latched).
  - `snes_data` = shift register bit 0.
  - Index = 0; clock edges are ignored.
  - `latch_fall` → SHIFT. The value loaded in the cycle of `latch_fall` is the frame's value.
  - `host_active` ← 1 and the timeout counter clears on `latch_rise`.
- SHIFT:
  - On each `clk_rise`: shift right (fill with 0), index++, `snes_data` = new bit 0.
  - When index reaches 16, `frame_done` pulses for one cycle, `frame_count`++ (8'hFF wraps to 0), → DONE.
- DONE: `snes_data` = 0 (a real pad drives low after 16 bits). `latch_rise` → LOAD.

Boundary conditions
- `latch_rise` in SHIFT or DONE aborts the frame: → LOAD, no `frame_done`, `frame_count` unchanged.
- Latch high has priority over any simultaneous clock edge.
- `clk_rise` in IDLE or DONE is ignored. Clock edges beyond 16 leave `snes_data` at 0.
- Timeout counter:
  - Counts `clock` cycles, saturating at CLOCK_FREQ_HZ/1_000_000 × TIMEOUT_US.
  - On reaching that value, `host_active` ← 0 and state → IDLE, even if mid-frame.
  - Counter width is ceil(log2) of that value.
- `reset_n` asserted mid-frame forces all reset values immediately. No frame completes; the next frame needs a fresh latch.
- A `buttons` change during SHIFT does not affect the frame in progress.

Test Plan:
1. Reset: assert `reset_n` = 0 mid-SHIFT → `snes_data` = 1, `frame_count` = 0, `host_active` = 0 within the same cycle (asynchronous reset).
2. Normal frame: `buttons` = 16'h0001 (B pressed), latch pulse 12 µs, then 16 clock pulses of 6 µs each → host samples 0 then fifteen 1s; `frame_done` pulses once; `frame_count` = 1.
3. Ordering: `buttons` = 16'hA5C3 → the 16 wire bits, LSB first, equal ~16'hA5C3, each appearing 5 clocks after the corresponding `snes_clock` rising edge (first bit 5 clocks after the latch rising edge); a 17th and 18th clock pulse read 0.
4. Abort: latch re-asserted after 7 clock pulses → no `frame_done`, `frame_count` unchanged, `snes_data` = ~`buttons`[0] again.
5. Glitch: a 1-cycle low pulse on `snes_clock` (with FILTER_CYCLES = 2) → no shift; a 3-cycle pulse → exactly one shift.
6. Timeout: 200 frames, then no latch for TIMEOUT_US + 1 µs → `frame_count` = 200 (wraps correctly past 255 when run to 260 frames, reading 4); `host_active` falls to 0 and rises again on the next latch.

Source files
------------

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device (pad) side of the SNES controller serial link.
// The host pulses snes_latch to capture the button word, then clocks it out
// LSB first on snes_clock rising edges. Data on the wire is active-low.
//
// Ports:
//   clock        system clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   buttons      16-bit button word, 1 = pressed, bit 0 (B) sent first
//   snes_latch   host latch, asynchronous to clock
//   snes_clock   host shift clock, idles high, asynchronous to clock
//   snes_data    serial data to host, active-low
//   frame_done   one-cycle pulse once the 16th bit has been shifted past
//   frame_count  completed frames, wraps
//   host_active  high while latches keep arriving within the timeout
module snes_pad_responder #(
  parameter int unsigned CLOCK_FREQ_HZ = 18181818,
  parameter int unsigned TIMEOUT_US    = 50000,
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] buttons,
  input  logic        snes_latch,
  input  logic        snes_clock,
  output logic        snes_data,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        host_active
);

  localparam int unsigned TimeoutCycles = (CLOCK_FREQ_HZ / 1000000) * TIMEOUT_US;
  // +1 so the saturation value itself is representable when it is a power of two.
  localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);
  localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TimeoutCycles);
  localparam logic [2:0] FiltLast = 3'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [1:0]          latch_sync_q, latch_sync_d, clk_sync_q, clk_sync_d;
  logic [2:0]          latch_cnt_q, latch_cnt_d, clk_cnt_q, clk_cnt_d;
  logic                latch_filt_q, latch_filt_d, clk_filt_q, clk_filt_d;
  logic                latch_prev_q, latch_prev_d, clk_prev_q, clk_prev_d;
  logic                latch_rise, latch_fall, clk_rise;
  state_e              state_q, state_d;
  logic [15:0]         shift_q, shift_d;
  logic [4:0]          idx_q, idx_d;
  logic                data_q, data_d;
  logic                done_q, done_d;
  logic [7:0]          count_q, count_d;
  logic                active_q, active_d;
  logic [TimeoutW-1:0] timeout_q, timeout_d;

  // Synchronizers and glitch filters. A filtered level only moves after
  // FILTER_CYCLES consecutive synchronized samples disagree with it.
  always_comb begin
    latch_sync_d = {latch_sync_q[0], snes_latch};
    clk_sync_d   = {clk_sync_q[0], snes_clock};
    latch_prev_d = latch_filt_q;
    clk_prev_d   = clk_filt_q;

    latch_filt_d = latch_filt_q;
    latch_cnt_d  = '0;
    if (latch_sync_q[1] != latch_filt_q) begin
      if (latch_cnt_q == FiltLast) latch_filt_d = latch_sync_q[1];
      else                         latch_cnt_d  = latch_cnt_q + 3'd1;
    end

    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FiltLast) clk_filt_d = clk_sync_q[1];
      else                       clk_cnt_d  = clk_cnt_q + 3'd1;
    end
  end

  assign latch_rise = latch_filt_q & ~latch_prev_q;
  assign latch_fall = ~latch_filt_q & latch_prev_q;
  assign clk_rise   = clk_filt_q & ~clk_prev_q;

  // Frame state machine, timeout and the registered wire output.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    count_d   = count_q;
    active_d  = active_q;
    timeout_d = timeout_q;
    data_d    = 1'b1;

    if (timeout_q != TimeoutMax) timeout_d = timeout_q + TimeoutW'(1);

    case (state_q)
      StLoad: begin
        // Transparent while latched; the value loaded on latch_fall is the frame.
        shift_d = ~buttons;
        idx_d   = '0;
        if (latch_fall) state_d = StShift;
      end
      StShift: begin
        if (clk_rise) begin
          shift_d = {1'b0, shift_q[15:1]};
          idx_d   = idx_q + 5'd1;
          if (idx_q == 5'd15) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
            state_d = StDone;
          end
        end
      end
      default: ;
    endcase

    // A latch rise starts (or aborts into) a new frame from any state and wins
    // over a simultaneous clock edge. Loading here keeps the first bit on time.
    if (latch_rise) begin
      state_d   = StLoad;
      shift_d   = ~buttons;
      idx_d     = '0;
      done_d    = 1'b0;
      count_d   = count_q;
      active_d  = 1'b1;
      timeout_d = '0;
    end else if (timeout_q == TimeoutMax) begin
      active_d = 1'b0;
      state_d  = StIdle;
    end

    case (state_d)
      StIdle:          data_d = 1'b1;
      StLoad, StShift: data_d = shift_d[0];
      default:         data_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q <= 2'b00;
      clk_sync_q   <= 2'b11;
      latch_cnt_q  <= '0;
      clk_cnt_q    <= '0;
      latch_filt_q <= 1'b0;
      clk_filt_q   <= 1'b1;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b1;
      state_q      <= StIdle;
      shift_q      <= 16'hFFFF;
      idx_q        <= '0;
      data_q       <= 1'b1;
      done_q       <= 1'b0;
      count_q      <= '0;
      active_q     <= 1'b0;
      timeout_q    <= '0;
    end else begin
      latch_sync_q <= latch_sync_d;
      clk_sync_q   <= clk_sync_d;
      latch_cnt_q  <= latch_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      latch_filt_q <= latch_filt_d;
      clk_filt_q   <= clk_filt_d;
      latch_prev_q <= latch_prev_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      done_q       <= done_d;
      count_q      <= count_d;
      active_q     <= active_d;
      timeout_q    <= timeout_d;
    end
  end

  assign snes_data   = data_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign host_active = active_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder. 4 clocks per microsecond, 500 us
// timeout (2000 clocks), FILTER_CYCLES = 2 so pin-to-data latency is 5 clocks.
// Inputs are driven on the falling clock edge and outputs sampled there too.
module tb_snes_pad_responder;

  localparam int unsigned ClkHz     = 4000000;
  localparam int unsigned TimeoutUs = 500;
  localparam int unsigned Filter    = 2;
  localparam int          Half      = 24;  // 6 us half period of the host clock

  logic        clock;
  logic        reset_n;
  logic [15:0] buttons;
  logic        snes_latch;
  logic        snes_clock;
  logic        snes_data;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        host_active;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] btn;
    int          np;
    logic [15:0] exp_wire;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [6];

  snes_pad_responder #(
    .CLOCK_FREQ_HZ(ClkHz),
    .TIMEOUT_US   (TimeoutUs),
    .FILTER_CYCLES(Filter)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .snes_latch (snes_latch),
    .snes_clock (snes_clock),
    .snes_data  (snes_data),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .host_active(host_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts clock cycles during which frame_done is high.
  always @(posedge clock) if (frame_done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // np host clock pulses; samp[k] is read just before rising edge k, and
  // samp[np] after the last pulse has settled. The button word is flipped
  // once shifting is underway.
  task automatic pulses(input int half, input int np, output logic [31:0] samp);
    samp = '0;
    for (int k = 0; k < np; k++) begin
      snes_clock = 1'b0;
      cyc(half);
      samp[k] = snes_data;
      if (k == 1) buttons = ~buttons;
      snes_clock = 1'b1;
      cyc(half);
    end
    cyc(8);
    samp[np] = snes_data;
  endtask

  task automatic run_frame(input logic [15:0] b, input int half, input int np,
                           output logic [31:0] samp);
    buttons    = b;
    snes_latch = 1'b1;
    cyc(2 * half);
    snes_latch = 1'b0;
    pulses(half, np, samp);
  endtask

  initial begin
    logic [31:0] samp;
    int          d0;

    reset_n    = 1'b0;
    buttons    = '0;
    snes_latch = 1'b0;
    snes_clock = 1'b1;
    cyc(2);
    check("reset_data", 32'(snes_data), 32'd1);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_count", 32'(frame_count), 32'd0);
    check("reset_active", 32'(host_active), 32'd0);
    reset_n = 1'b1;
    cyc(10);
    check("idle_data", 32'(snes_data), 32'd1);

    vecs[0] = '{16'h0001, 16, 16'hFFFE, 8'd1};
    vecs[1] = '{16'hA5C3, 18, 16'h5A3C, 8'd2};
    vecs[2] = '{16'hFFFF, 16, 16'h0000, 8'd3};
    vecs[3] = '{16'h0000, 16, 16'hFFFF, 8'd4};
    vecs[4] = '{16'h8000, 16, 16'h7FFF, 8'd5};
    vecs[5] = '{16'h1234, 16, 16'hEDCB, 8'd6};

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_frame(vecs[i].btn, Half, vecs[i].np, samp);
      check($sformatf("vec%0d_wire", i), 32'(samp[15:0]), 32'(vecs[i].exp_wire));
      check($sformatf("vec%0d_tail", i), samp >> 16, 32'd0);
      check($sformatf("vec%0d_done", i), done_cnt - d0, 32'd1);
      check($sformatf("vec%0d_count", i), 32'(frame_count), 32'(vecs[i].exp_count));
    end
    check("active_after_frames", 32'(host_active), 32'd1);

    // Abort: re-latch after 7 pulses; a clock pulse during the latch is ignored.
    d0         = done_cnt;
    buttons    = 16'h0001;
    snes_latch = 1'b1;
    cyc(2 * Half);
    snes_latch = 1'b0;
    for (int k = 0; k < 7; k++) begin
      snes_clock = 1'b0;
      cyc(Half);
      snes_clock = 1'b1;
      cyc(Half);
    end
    check("abort_bit7", 32'(snes_data), 32'd1);
    snes_latch = 1'b1;
    cyc(8);
    check("abort_reload", 32'(snes_data), 32'd0);
    snes_clock = 1'b0;
    cyc(4);
    snes_clock = 1'b1;
    cyc(Half);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_count", 32'(frame_count), 32'd6);
    snes_latch = 1'b0;
    pulses(Half, 16, samp);
    check("post_abort_wire", 32'(samp[15:0]), 32'h0000FFFE);
    check("post_abort_done", done_cnt - d0, 32'd1);
    check("post_abort_count", 32'(frame_count), 32'd7);

    // Glitch filter on the host clock: ~16'h0005 = ...1010 on the wire.
    buttons    = 16'h0005;
    snes_latch = 1'b1;
    cyc(2 * Half);
    snes_latch = 1'b0;
    cyc(Half);
    check("glitch_bit0", 32'(snes_data), 32'd0);
    snes_clock = 1'b0;
    cyc(1);
    snes_clock = 1'b1;
    cyc(12);
    check("glitch_1cyc_no_shift", 32'(snes_data), 32'd0);
    snes_clock = 1'b0;
    cyc(3);
    snes_clock = 1'b1;
    cyc(12);
    check("glitch_3cyc_one_shift", 32'(snes_data), 32'd1);
    snes_clock = 1'b0;
    cyc(4);
    snes_clock = 1'b1;
    cyc(12);
    check("glitch_next_bit", 32'(snes_data), 32'd0);

    // Asynchronous reset mid-frame, checked before the next rising edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_data", 32'(snes_data), 32'd1);
    check("rst_async_count", 32'(frame_count), 32'd0);
    check("rst_async_active", 32'(host_active), 32'd0);
    check("rst_async_done", 32'(frame_done), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      snes_clock = 1'b0;
      cyc(4);
      snes_clock = 1'b1;
      cyc(12);
    end
    check("post_rst_needs_latch", 32'(snes_data), 32'd1);
    check("post_rst_count", 32'(frame_count), 32'd0);

    // 200 fast frames, then silence past the timeout.
    d0 = done_cnt;
    for (int f = 0; f < 200; f++) run_frame(16'(f), 4, 16, samp);
    check("bulk_count_200", 32'(frame_count), 32'd200);
    check("bulk_done_200", done_cnt - d0, 32'd200);
    cyc(1600);
    check("active_before_timeout", 32'(host_active), 32'd1);
    cyc(404);
    check("active_after_timeout", 32'(host_active), 32'd0);
    check("timeout_idle_data", 32'(snes_data), 32'd1);

    // Fresh latch after timeout: 5-clock latency on latch and on a clock edge.
    d0         = done_cnt;
    buttons    = 16'hA5C3;
    snes_latch = 1'b1;
    cyc(4);
    check("lat_rise_4clk", 32'(snes_data), 32'd1);
    check("active_4clk", 32'(host_active), 32'd0);
    cyc(1);
    check("lat_rise_5clk", 32'(snes_data), 32'd0);
    check("active_back", 32'(host_active), 32'd1);
    cyc(2 * Half - 5);
    snes_latch = 1'b0;
    for (int k = 0; k < 16; k++) begin
      snes_clock = 1'b0;
      cyc(Half);
      snes_clock = 1'b1;
      if (k == 1) begin
        cyc(4);
        check("clk_rise_4clk", 32'(snes_data), 32'd0);
        cyc(1);
        check("clk_rise_5clk", 32'(snes_data), 32'd1);
        cyc(Half - 5);
      end else begin
        cyc(Half);
      end
    end
    cyc(8);
    check("latency_frame_done", done_cnt - d0, 32'd1);
    check("count_201", 32'(frame_count), 32'd201);

    for (int f = 0; f < 59; f++) run_frame(16'(f + 7), 4, 16, samp);
    check("count_wrap_260", 32'(frame_count), 32'd4);
    check("active_end", 32'(host_active), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
